// File: rtl/tx_link_scheduler.sv
// tx_link_scheduler: brings the 8b/10b link out of electrical idle, trains it with COM
// symbols, then round-robins two requesters onto the transmitter one slot at a time.
module tx_link_scheduler #(
    parameter int ELEC_IDLE_CYC = 16,
    parameter int TRAIN_SETS    = 4,
    parameter int BYTE_CYC      = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        link_en,
    input  logic        req0_valid,
    input  logic [31:0] req0_data,
    input  logic [1:0]  req0_size,
    input  logic        req0_k,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_data,
    input  logic [1:0]  req1_size,
    input  logic        req1_k,
    output logic        req1_ready,
    output logic        enb,
    output logic        TxElecIdle,
    output logic        K,
    output logic [1:0]  dataS,
    output logic [7:0]  dataIn8,
    output logic [15:0] dataIn16,
    output logic [31:0] dataIn32,
    output logic        link_up
);
    localparam int IW = $clog2(ELEC_IDLE_CYC + 1);
    localparam int SW = $clog2(4 * BYTE_CYC);
    localparam int TW = $clog2(TRAIN_SETS + 1);

    typedef enum logic [1:0] {ELEC_IDLE, TRAIN, ACTIVE} state_t;

    state_t        r_state;
    logic [IW-1:0] r_idle;
    logic [SW-1:0] r_slot;
    logic [TW-1:0] r_train;
    logic          r_rr;

    logic [SW-1:0] w_last;
    logic          w_bnd;
    logic          w_win;
    logic          w_g0;
    logic          w_g1;
    logic [1:0]    w_size;
    logic [31:0]   w_data;
    logic          w_k;

    // slot length follows the width currently on the wire: 1, 2 or 4 bytes
    assign w_last = dataS == 2'b10 ? SW'(4 * BYTE_CYC - 1) :
                    dataS == 2'b01 ? SW'(2 * BYTE_CYC - 1) : SW'(BYTE_CYC - 1);
    assign w_bnd  = r_slot == w_last;
    assign w_win  = r_state == ACTIVE && w_bnd && link_en;
    assign w_g1   = req1_valid && (!req0_valid || r_rr);
    assign w_g0   = req0_valid && !w_g1;
    assign req0_ready = w_win && w_g0;
    assign req1_ready = w_win && w_g1;
    assign w_size = w_g1 ? req1_size : req0_size;
    assign w_data = w_g1 ? req1_data : req0_data;
    assign w_k    = w_g1 ? req1_k : req0_k;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ELEC_IDLE;
            r_idle     <= '0;
            r_slot     <= '0;
            r_train    <= '0;
            r_rr       <= 1'b0;
            enb        <= 1'b0;
            TxElecIdle <= 1'b1;
            K          <= 1'b0;
            dataS      <= 2'b00;
            dataIn8    <= '0;
            dataIn16   <= '0;
            dataIn32   <= '0;
            link_up    <= 1'b0;
        end else if (r_state == ELEC_IDLE) begin
            if (!link_en)
                r_idle <= '0;
            else if (r_idle == IW'(ELEC_IDLE_CYC - 1)) begin
                r_state    <= TRAIN;
                r_idle     <= '0;
                r_train    <= '0;
                enb        <= 1'b1;
                TxElecIdle <= 1'b0;
                K          <= 1'b1;
                dataIn8    <= 8'hBC;
            end else
                r_idle <= r_idle + 1'b1;
        end else if (!w_bnd)
            r_slot <= r_slot + 1'b1;
        else begin
            // every boundary defaults to filler; the branches below override it
            r_slot   <= '0;
            K        <= 1'b0;
            dataS    <= 2'b00;
            dataIn8  <= '0;
            dataIn16 <= '0;
            dataIn32 <= '0;
            if (!link_en) begin
                r_state    <= ELEC_IDLE;
                enb        <= 1'b0;
                TxElecIdle <= 1'b1;
                link_up    <= 1'b0;
            end else if (r_state == TRAIN && r_train != TW'(TRAIN_SETS - 1)) begin
                r_train <= r_train + 1'b1;
                K       <= 1'b1;
                dataIn8 <= 8'hBC;
            end else if (r_state == TRAIN) begin
                r_state <= ACTIVE;
                link_up <= 1'b1;
            end else if (w_g0 || w_g1) begin
                dataS    <= w_size == 2'b11 ? 2'b00 : w_size;
                dataIn32 <= w_data;
                dataIn16 <= w_data[15:0];
                dataIn8  <= w_data[7:0];
                K        <= w_k && (w_size == 2'b00 || w_size == 2'b11);
                r_rr     <= w_g0;
            end
        end
    end
endmodule

// File: tb/tb_tx_link_scheduler.sv
// tb_tx_link_scheduler: directed and random stimulus for tx_link_scheduler, checked every
// cycle against a slot-time reference model of the link sequencing and arbitration.
module tb_tx_link_scheduler;
    logic        clk = 0;
    logic        rst = 0;
    logic        link_en = 0;
    logic        req0_valid = 0, req0_k = 0, req1_valid = 0, req1_k = 0;
    logic [31:0] req0_data = 0, req1_data = 0;
    logic [1:0]  req0_size = 0, req1_size = 0;
    logic        req0_ready, req1_ready, enb, TxElecIdle, K, link_up;
    logic [1:0]  dataS;
    logic [7:0]  dataIn8;
    logic [15:0] dataIn16;
    logic [31:0] dataIn32;

    tx_link_scheduler dut (
        .clk(clk), .rst(rst), .link_en(link_en),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_size(req0_size),
        .req0_k(req0_k), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_size(req1_size),
        .req1_k(req1_k), .req1_ready(req1_ready),
        .enb(enb), .TxElecIdle(TxElecIdle), .K(K), .dataS(dataS),
        .dataIn8(dataIn8), .dataIn16(dataIn16), .dataIn32(dataIn32), .link_up(link_up)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0, cyc = 0;
    // reference model: mode 0 idle, 1 training, 2 active; m_left = cycles left in slot
    int m_mode, m_streak, m_left, m_sets, m_last;
    logic        m_k;
    logic [1:0]  m_ds;
    logic [7:0]  m_d8;
    logic [15:0] m_d16;
    logic [31:0] m_d32;
    logic acc0 = 0, acc1 = 0, obs_r0 = 0, obs_r1 = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_streak = 0; m_left = 0; m_sets = 0; m_last = 1;
        m_k = 0; m_ds = 0; m_d8 = 0; m_d16 = 0; m_d32 = 0;
    endtask

    function automatic int pick();
        if (!(m_mode == 2 && m_left == 1 && link_en)) return -1;
        if (req0_valid && req1_valid) return m_last == 0 ? 1 : 0;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    task automatic model_step();
        int g;
        logic [1:0] sz;
        logic [31:0] d;
        g = pick();
        if (m_mode == 0) begin
            m_streak = link_en ? m_streak + 1 : 0;
            if (m_streak == 16) begin
                m_mode = 1; m_streak = 0; m_sets = 0;
                m_k = 1; m_ds = 0; m_d8 = 8'hBC; m_d16 = 0; m_d32 = 0; m_left = 10;
            end
        end else begin
            m_left--;
            if (m_left == 0) begin
                m_k = 0; m_ds = 0; m_d8 = 0; m_d16 = 0; m_d32 = 0;
                if (!link_en) m_mode = 0;
                else if (m_mode == 1) begin
                    m_sets++;
                    if (m_sets < 4) begin m_k = 1; m_d8 = 8'hBC; end
                    else m_mode = 2;
                end else if (g >= 0) begin
                    sz = g == 1 ? req1_size : req0_size;
                    d  = g == 1 ? req1_data : req0_data;
                    m_ds = sz == 2'b11 ? 2'b00 : sz;
                    m_d32 = d; m_d16 = d[15:0]; m_d8 = d[7:0];
                    m_k = (sz == 2'b00 || sz == 2'b11) && (g == 1 ? req1_k : req0_k);
                    m_last = g;
                end
                m_left = 10 << m_ds;
            end
        end
    endtask

    // called at a falling edge with inputs already applied; checks, then crosses one rising edge
    task automatic tick();
        int g;
        #1;
        g = pick();
        obs_r0 = req0_ready; obs_r1 = req1_ready;
        chk("ready0", req0_ready, g == 0);
        chk("ready1", req1_ready, g == 1);
        chk("enb", enb, m_mode != 0);
        chk("elecidle", TxElecIdle, m_mode == 0);
        chk("link_up", link_up, m_mode == 2);
        chk("K", K, m_k);
        chk("dataS", dataS, m_ds);
        chk("dataIn8", dataIn8, m_d8);
        chk("dataIn16", dataIn16, m_d16);
        chk("dataIn32", dataIn32, m_d32);
        acc0 = g == 0; acc1 = g == 1;
        if (!rst) model_reset(); else model_step();
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic wait_acc(input string tag);
        int n = 0;
        do begin tick(); n++; end while (!(obs_r0 || obs_r1) && n < 300);
        chk(tag, obs_r0 || obs_r1, 1);
    endtask

    task automatic drive_req(input int rate);
        if (acc0) req0_valid = 0;
        if (acc1) req1_valid = 0;
        if (!req0_valid && $urandom_range(99) < rate) begin
            req0_valid = 1; req0_data = $urandom; req0_size = 2'($urandom); req0_k = 1'($urandom);
        end
        if (!req1_valid && $urandom_range(99) < rate) begin
            req1_valid = 1; req1_data = $urandom; req1_size = 2'($urandom); req1_k = 1'($urandom);
        end
    endtask

    initial begin
        int n, c0;
        model_reset();
        @(negedge clk);
        tick(); tick();
        // bring-up: idle 0-15, COM 16-55, first active filler 56-65
        rst = 1; link_en = 1; cyc = 0;
        run_to(15); #1 chk("t1_idle15", TxElecIdle, 1);
        run_to(16); #1 chk("t1_com16", {K, dataIn8}, 9'h1BC);
        run_to(55); #1 chk("t1_com55", {K, dataIn8}, 9'h1BC);
        run_to(56); #1 chk("t1_up56", {link_up, dataIn8}, 9'h100);
        // single 32-bit word from req0
        run_to(60);
        req0_valid = 1; req0_size = 2'b10; req0_data = 32'h0123456F; req0_k = 0;
        run_to(64); #1 chk("t2_rdy64", req0_ready, 0);
        run_to(65); #1 chk("t2_rdy65", req0_ready, 1);
        tick(); req0_valid = 0;
        #1 chk("t2_word66", {dataS, dataIn32}, {2'b10, 32'h0123456F});
        run_to(105); #1 chk("t2_word105", {dataS, dataIn32}, {2'b10, 32'h0123456F});
        // both valid: req1 goes first since req0 was served last
        req0_valid = 1; req0_data = 32'hCC; req0_size = 2'b00; req0_k = 0;
        req1_valid = 1; req1_data = 32'hABCD; req1_size = 2'b01; req1_k = 0;
        n = 0; c0 = 0;
        while (n < 6 && c0 < 300) begin
            tick(); c0++;
            if (obs_r0 || obs_r1) begin chk("t3_alt", obs_r1, n % 2 == 0); n++; end
        end
        chk("t3_grants", n, 6);
        req0_valid = 0; req1_valid = 0;
        // no requests: filler only
        repeat (40) tick();
        #1 chk("t4_noready", {req0_ready, req1_ready, K}, 0);
        // drop link_en five cycles into a 32-bit slot
        req0_valid = 1; req0_size = 2'b10; req0_data = $urandom;
        wait_acc("t5_acc");
        req0_valid = 0;
        repeat (5) tick();
        link_en = 0;
        repeat (34) tick();
        #1 chk("t5_lastcyc", {enb, link_up, dataS}, {1'b1, 1'b1, 2'b10});
        tick();
        #1 chk("t5_idle", {enb, TxElecIdle, link_up}, 3'b010);
        repeat (7) tick();
        link_en = 1; c0 = cyc;
        run_to(c0 + 15); #1 chk("t5_reidle", TxElecIdle, 1);
        run_to(c0 + 16); #1 chk("t5_recom", {K, dataIn8}, 9'h1BC);
        run_to(c0 + 56); #1 chk("t5_reup", link_up, 1);
        // size 11 behaves as 8-bit and keeps K; 16-bit drops K
        req0_valid = 1; req0_size = 2'b11; req0_k = 1; req0_data = 32'h7777775A;
        wait_acc("t6_acc11");
        req0_valid = 0;
        #1 chk("t6_size11", {dataS, K, dataIn8}, {2'b00, 1'b1, 8'h5A});
        req0_valid = 1; req0_size = 2'b01; req0_k = 1; req0_data = 32'h00001234;
        wait_acc("t6_acc01");
        req0_valid = 0;
        #1 chk("t6_size01", {dataS, K, dataIn16}, {2'b01, 1'b0, 16'h1234});
        // random traffic with occasional link drops
        repeat (2500) begin
            drive_req(30);
            link_en = link_en ? ($urandom_range(299) != 0) : ($urandom_range(9) == 0);
            tick();
        end
        req0_valid = 0; req1_valid = 0; link_en = 1;
        // reset in the middle of a 32-bit slot
        req1_valid = 1; req1_size = 2'b10; req1_data = $urandom;
        wait_acc("t6_accrst");
        req1_valid = 0;
        repeat (3) tick();
        #2 rst = 0;
        #1 model_reset();
        chk("t6_rst_now", {enb, TxElecIdle, link_up, K, dataS}, 6'b010000);
        chk("t6_rst_data", dataIn32, 0);
        @(negedge clk);
        tick();
        rst = 1;
        repeat (30) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
